// File: rtl/fg_pkg.sv
// fg_pkg -- shared definitions for the function generator configuration path.
//
// Contents:
//   - Default configuration word width.
//   - Bit positions of each field inside the configuration word, so the
//     generator and any helper logic agree on where each field lives.
//   - State encoding of the SPI configuration slave.
package fg_pkg;

  localparam int CFG_BITWIDTH_DEFAULT = 64;

  // Configuration word field positions (MSB/LSB inclusive).
  localparam int CFG_CS_MODE_BIT     = 63;
  localparam int CFG_MS_MODE_BIT     = 62;
  localparam int CFG_RADIX_BIT       = 61;
  localparam int CFG_PRESCALER_MSB   = 60;
  localparam int CFG_PRESCALER_LSB   = 52;
  localparam int CFG_COUNTER_MSB     = 51;
  localparam int CFG_COUNTER_LSB     = 42;
  localparam int CFG_PHASE_ON_MSB    = 41;
  localparam int CFG_PHASE_ON_LSB    = 32;
  localparam int CFG_RISE_MSB        = 31;
  localparam int CFG_RISE_LSB        = 24;
  localparam int CFG_FALL_MSB        = 23;
  localparam int CFG_FALL_LSB        = 16;
  localparam int CFG_AMPLITUDE_MSB   = 15;
  localparam int CFG_AMPLITUDE_LSB   = 8;
  localparam int CFG_OFFSET_MSB      = 7;
  localparam int CFG_OFFSET_LSB      = 0;

  // SPI slave states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/fg_sync_edge.sv
// fg_sync_edge -- multi-flop synchroniser with edge detection.
//
// An asynchronous input is passed through SYNC_STAGES flip-flops. The last
// stage is the synced level; a one-cycle-delayed copy of it gives single-cycle
// rise and fall pulses. On reset every flop takes RESET_LEVEL so no spurious
// edge is reported when reset is released with the pin at its idle level.
//
// Ports:
//   clk_i  in   system clock
//   rst_n  in   synchronous active-low reset
//   din    in   asynchronous input
//   level  out  synchronised level
//   rise   out  one-cycle pulse on a synced 0->1 transition
//   fall   out  one-cycle pulse on a synced 1->0 transition
module fg_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  // Stage 0 samples the pin; each later stage samples the one before it.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      sync_reg <= {SYNC_STAGES{RESET_LEVEL}};
      prev_reg <= RESET_LEVEL;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign fall  = ~sync_reg[SYNC_STAGES-1] & prev_reg;

endmodule

// File: rtl/fg_spi_config.sv
// fg_spi_config -- SPI mode-0 slave holding the function generator
// configuration word.
//
// A frame is CONFIG_REG_BITWIDTH bits, MSB first, framed by chip select.
// The configuration bus only changes when a frame of exactly the right
// length completes; wrong-length frames leave the bus alone and raise a
// sticky error flag that the next good frame clears. While a frame is being
// received the currently committed word is shifted out on MISO.
//
// Ports:
//   clk_i             in   system clock (>= 8x SCLK)
//   rst_n             in   synchronous active-low reset
//   spi_sclk_i        in   SPI clock, asynchronous, idles low
//   spi_csn_i         in   chip select, active-low, asynchronous
//   spi_mosi_i        in   serial data in, MSB first
//   spi_miso_o        out  readback of committed word, MSB first
//   CR_bus_o          out  committed configuration word
//   cfgUpdate_STRB_o  out  one-cycle pulse in the cycle CR_bus_o changes
//   frameError_o      out  sticky: last frame had the wrong bit count
module fg_spi_config
  import fg_pkg::*;
#(
  parameter int                             CONFIG_REG_BITWIDTH = fg_pkg::CFG_BITWIDTH_DEFAULT,
  parameter int                             SYNC_STAGES         = 2,
  parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_CONFIG        = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  input  logic                           spi_sclk_i,
  input  logic                           spi_csn_i,
  input  logic                           spi_mosi_i,
  output logic                           spi_miso_o,
  output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
  output logic                           cfgUpdate_STRB_o,
  output logic                           frameError_o
);

  localparam int W     = CONFIG_REG_BITWIDTH;
  // Counter must hold W+1 so an over-long frame is distinguishable from W.
  localparam int CNT_W = $clog2(W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(W + 1);

  // ---------------------------------------------------------------------
  // Input synchronisation
  // ---------------------------------------------------------------------
  logic sclk_level_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic csn_level;
  logic csn_rise;
  logic csn_fall_unused;
  logic mosi_level;
  logic mosi_rise_unused;
  logic mosi_fall_unused;

  fg_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (1'b0)
  ) u_sync_sclk (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .din   (spi_sclk_i),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  fg_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (1'b1)
  ) u_sync_csn (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .din   (spi_csn_i),
    .level (csn_level),
    .rise  (csn_rise),
    .fall  (csn_fall_unused)
  );

  fg_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (1'b0)
  ) u_sync_mosi (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .din   (spi_mosi_i),
    .level (mosi_level),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  spi_state_e     state_reg,    state_next;
  logic [W-1:0]   shift_reg,    shift_next;
  logic [W-1:0]   readback_reg, readback_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic [W-1:0]   cr_reg,       cr_next;
  logic           strobe_reg,   strobe_next;
  logic           err_reg,      err_next;
  logic           miso_reg,     miso_next;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      readback_reg <= '0;
      cnt_reg      <= '0;
      cr_reg       <= RESET_CONFIG;
      strobe_reg   <= 1'b0;
      err_reg      <= 1'b0;
      miso_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      readback_reg <= readback_next;
      cnt_reg      <= cnt_next;
      cr_reg       <= cr_next;
      strobe_reg   <= strobe_next;
      err_reg      <= err_next;
      miso_reg     <= miso_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    readback_next = readback_reg;
    cnt_next      = cnt_reg;
    cr_next       = cr_reg;
    strobe_next   = 1'b0;
    err_next      = err_reg;
    miso_next     = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        // Level check (not edge) so a csn that re-asserts while COMMIT is
        // still running is picked up here on the following cycle.
        if (!csn_level) begin
          readback_next = cr_reg;
          shift_next    = '0;
          cnt_next      = '0;
          state_next    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        miso_next = readback_reg[W-1];
        if (csn_rise) begin
          // End of frame takes priority over any coincident sclk edge.
          state_next = ST_COMMIT;
        end else begin
          if (sclk_rise) begin
            // Bits beyond the frame length are dropped; the counter still
            // records that they happened so the frame is rejected.
            if (cnt_reg < CNT_FULL) begin
              shift_next = {shift_reg[W-2:0], mosi_level};
            end
            if (cnt_reg != CNT_SAT) begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          if (sclk_fall) begin
            readback_next = {readback_reg[W-2:0], 1'b0};
          end
        end
      end

      ST_COMMIT: begin
        state_next = ST_IDLE;
        if (cnt_reg == CNT_FULL) begin
          // Bus and strobe registers load together, so the strobe is high
          // exactly in the cycle the new word appears.
          cr_next     = shift_reg;
          strobe_next = 1'b1;
          err_next    = 1'b0;
        end else begin
          err_next    = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign spi_miso_o       = miso_reg;
  assign CR_bus_o         = cr_reg;
  assign cfgUpdate_STRB_o = strobe_reg;
  assign frameError_o     = err_reg;

endmodule

// File: tb/tb_fg_spi_config.sv
// tb_fg_spi_config -- self-checking bench for fg_spi_config.
module tb_fg_spi_config;
  import fg_pkg::*;

  localparam int W  = 64;
  localparam int SS = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk  = 1'b0;
  logic          csn   = 1'b1;
  logic          mosi  = 1'b0;
  logic          miso;
  logic [W-1:0]  cr;
  logic          strb;
  logic          ferr;

  always #5 clk = ~clk;

  fg_spi_config #(
    .CONFIG_REG_BITWIDTH (W),
    .SYNC_STAGES         (SS),
    .RESET_CONFIG        (64'h0)
  ) dut (
    .clk_i            (clk),
    .rst_n            (rst_n),
    .spi_sclk_i       (sclk),
    .spi_csn_i        (csn),
    .spi_mosi_i       (mosi),
    .spi_miso_o       (miso),
    .CR_bus_o         (cr),
    .cfgUpdate_STRB_o (strb),
    .frameError_o     (ferr)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           nbits;
    logic [63:0]  data;
    logic [63:0]  exp_cr;
    logic         exp_err;
    logic         exp_strobe;
    logic         chk_rb;
    logic [63:0]  exp_rb;
  } vec_t;

  typedef struct {
    logic [63:0] prev_cr;
    logic [63:0] cr;
    logic        err;
    logic        strobe;
    logic        chk_rb;
    logic [63:0] rb;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Clocks out nbits bits (extra zeros beyond 64), capturing MISO just before
  // each rising SCLK edge. If raise_csn is 0 the frame is left open.
  task automatic send_bits(input int nbits, input logic [63:0] data,
                           input bit raise_csn, output logic [63:0] cap);
    cap = '0;
    @(negedge clk);
    csn = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 64) ? data[63-i] : 1'b0;
      repeat (4) @(negedge clk);
      if (i < 64) cap[63-i] = miso;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    if (raise_csn) begin
      repeat (6) @(negedge clk);
      csn = 1'b1;
    end
  endtask

  // Called right after csn was raised on a negedge; posedge k is the k-th
  // clock edge after the pin change.
  task automatic check_commit(input int idx, input logic [63:0] cap);
    exp_t        e;
    int          nstrobe;
    int          strobe_k;
    logic [63:0] cr_before;
    logic [63:0] cr_at;
    nstrobe   = 0;
    strobe_k  = -1;
    cr_before = 'x;
    cr_at     = 'x;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (strb === 1'b1) begin
        nstrobe++;
        strobe_k = k;
      end
      if (k == SS + 1) cr_before = cr;
      if (k == SS + 2) cr_at = cr;
    end
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL frame%0d scoreboard empty actual=0 required=1", idx);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("frame%0d strobe_count", idx), 64'(nstrobe), e.strobe ? 64'd1 : 64'd0);
    if (e.strobe) begin
      check($sformatf("frame%0d strobe_cycle", idx), 64'(strobe_k), 64'(SS + 2));
      check($sformatf("frame%0d cr_before_latency", idx), cr_before, e.prev_cr);
      check($sformatf("frame%0d cr_at_latency", idx), cr_at, e.cr);
    end
    check($sformatf("frame%0d cr_final", idx), cr, e.cr);
    check($sformatf("frame%0d frame_error", idx), 64'(ferr), 64'(e.err));
    if (e.chk_rb) check($sformatf("frame%0d miso_readback", idx), cap, e.rb);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] cap;
    logic [63:0] last_cr;
    int          ns;
    exp_t        e;

    tbl[0] = '{64, 64'hA012_3456_789A_BCDE, 64'hA012_3456_789A_BCDE, 1'b0, 1'b1, 1'b1, 64'h0};
    tbl[1] = '{63, 64'h1234_5678_9ABC_DEF0, 64'hA012_3456_789A_BCDE, 1'b1, 1'b0, 1'b0, 64'h0};
    tbl[2] = '{64, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 1'b1, 64'hA012_3456_789A_BCDE};
    tbl[3] = '{65, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 1'b0, 64'h0};
    tbl[4] = '{0,  64'h0,                   64'h0000_0000_0000_0001, 1'b1, 1'b0, 1'b0, 64'h0};
    tbl[5] = '{64, 64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_0001};
    tbl[6] = '{64, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 1'b1, 64'hFFFF_0000_FFFF_0000};

    // Reset state.
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset cr", cr, 64'h0);
    check("reset strobe", 64'(strb), 64'h0);
    check("reset frame_error", 64'(ferr), 64'h0);
    check("reset miso", 64'(miso), 64'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // SCLK activity with csn high must be ignored.
    ns = 0;
    for (int i = 0; i < 20; i++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk = ~sclk;
      repeat (4) begin
        @(posedge clk);
        #1;
        if (strb === 1'b1) ns++;
      end
      @(negedge clk);
    end
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_sclk strobe_count", 64'(ns), 64'h0);
    check("idle_sclk cr", cr, 64'h0);
    check("idle_sclk state", 64'(dut.state_reg), 64'(ST_IDLE));

    // Table-driven frames.
    last_cr = 64'h0;
    for (int v = 0; v < 7; v++) begin
      e.prev_cr = last_cr;
      e.cr      = tbl[v].exp_cr;
      e.err     = tbl[v].exp_err;
      e.strobe  = tbl[v].exp_strobe;
      e.chk_rb  = tbl[v].chk_rb;
      e.rb      = tbl[v].exp_rb;
      exp_q.push_back(e);
      last_cr = tbl[v].exp_cr;
      send_bits(tbl[v].nbits, tbl[v].data, 1'b1, cap);
      check_commit(v, cap);
      repeat (6) @(negedge clk);
    end

    // Reset in the middle of a frame.
    send_bits(30, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0, cap);
    @(negedge clk);
    rst_n = 1'b0;
    csn   = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset cr", cr, 64'h0);
    check("midreset state", 64'(dut.state_reg), 64'(ST_IDLE));
    check("midreset strobe", 64'(strb), 64'h0);
    check("midreset miso", 64'(miso), 64'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    e.prev_cr = 64'h0;
    e.cr      = 64'h5A5A_5A5A_5A5A_5A5A;
    e.err     = 1'b0;
    e.strobe  = 1'b1;
    e.chk_rb  = 1'b1;
    e.rb      = 64'h0;
    exp_q.push_back(e);
    send_bits(64, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1, cap);
    check_commit(7, cap);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
